sdram_mem_tester: RTL and testbench

Bus-side initiator for the SDRAM controller request/response interface. On `start` it writes a deterministic pattern over a parameterised word range, then reads the range back one word at a time and compares. It reports pass/fail, error count and first-failure details. Used as the on-board self-test master in front of the SDRAM controller.

---
 rtl/sdram_params_pkg.sv | 7 +
 rtl/sdram_tester_pkg.sv | 14 +
 rtl/sdram_mem_tester_if.sv | 20 ++
 rtl/sdram_tester_watchdog.sv | 19 +
 rtl/sdram_mem_tester.sv | 100 ++++++++++
 tb/tb_sdram_mem_tester.sv | 222 ++++++++++++++++++++++
 6 files changed

// File: rtl/sdram_params_pkg.sv
// sdram_params_pkg: bus geometry shared by the SDRAM controller and its masters.
package sdram_params_pkg;
    localparam int AVS_AW   = 24;
    localparam int AVS_DW   = 16;
    localparam int AVS_BYTE = AVS_DW / 8;
    localparam int SDRAM_BL = 4;
endpackage

// File: rtl/sdram_tester_pkg.sv
// sdram_tester_pkg: tester FSM state encodings and the test pattern generator.
package sdram_tester_pkg;
    import sdram_params_pkg::*;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_WRITE      = 3'd1;
    localparam state_t S_READ_REQ   = 3'd2;
    localparam state_t S_READ_RESP  = 3'd3;
    localparam state_t S_READ_DRAIN = 3'd4;
    localparam state_t S_DONE       = 3'd5;
    function automatic logic [AVS_DW-1:0] pattern(input logic [31:0] seed, input logic [31:0] idx);
        return AVS_DW'(seed) ^ AVS_DW'(idx);
    endfunction
endpackage

// File: rtl/sdram_mem_tester_if.sv
// sdram_mem_tester_if: request/response bus between an SDRAM master and the controller.
interface sdram_mem_tester_if;
    import sdram_params_pkg::*;
    logic                bus_req_valid;
    logic                bus_req_write;
    logic [AVS_AW-1:0]   bus_req_address;
    logic [AVS_DW-1:0]   bus_req_writedata;
    logic [AVS_BYTE-1:0] bus_req_byteenable;
    logic                bus_req_ready;
    logic                bus_resp_valid;
    logic [AVS_DW-1:0]   bus_resp_readdata;
    modport master(
        output bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable,
        input  bus_req_ready, bus_resp_valid, bus_resp_readdata
    );
    modport slave(
        input  bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable,
        output bus_req_ready, bus_resp_valid, bus_resp_readdata
    );
endinterface

// File: rtl/sdram_tester_watchdog.sv
// sdram_tester_watchdog: loadable down-counter that flags expiry when it sits at zero.
module sdram_tester_watchdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic         expired
);
    logic [W-1:0] count;
    assign expired = count == '0;
    always_ff @(posedge clk) begin
        if (!reset) count <= '0;
        else if (load) count <= load_value;
        else if (en && !expired) count <= count - 1'b1;
    end
endmodule

// File: rtl/sdram_mem_tester.sv
// sdram_mem_tester: writes a seeded pattern over a word range, reads it back and
// reports mismatches; acts as the self-test master in front of the SDRAM controller.
module sdram_mem_tester
    import sdram_params_pkg::*, sdram_tester_pkg::*;
#(
    parameter logic [AVS_AW-1:0] ADDR_START = '0,
    parameter int                ADDR_COUNT = 1024,
    parameter logic [31:0]       SEED       = 32'hA5A5_5A5A,
    parameter int                TIMEOUT    = 4096,
    parameter int                ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  error_count,
    output logic [AVS_AW-1:0] fail_addr,
    output logic [AVS_DW-1:0] fail_data,
    output logic [AVS_DW-1:0] fail_expect,
    sdram_mem_tester_if.master bus
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    state_t            state, nxt;
    logic [31:0]       idx;
    logic [ERR_W-1:0]  err;
    logic [AVS_DW-1:0] exp_data;
    logic              last, acc, rsp, hit, wd_en, wd_exp, timeout_r;
    assign last     = idx == 32'(ADDR_COUNT - 1);
    assign exp_data = pattern(SEED, idx);
    // valid is gated by reset so a mid-transaction reset withdraws the request at once
    assign bus.bus_req_valid      = reset & (state == S_WRITE | state == S_READ_REQ);
    assign bus.bus_req_write      = state == S_WRITE;
    assign bus.bus_req_address    = ADDR_START + AVS_AW'(idx);
    assign bus.bus_req_writedata  = exp_data;
    assign bus.bus_req_byteenable = '1;
    assign acc   = bus.bus_req_valid & bus.bus_req_ready;
    assign rsp   = state == S_READ_RESP & bus.bus_resp_valid;
    assign wd_en = state == S_WRITE | state == S_READ_REQ | state == S_READ_RESP;
    assign hit   = wd_en & wd_exp & ~acc & ~rsp;
    assign busy        = wd_en | state == S_READ_DRAIN;
    assign done        = state == S_DONE;
    assign pass        = done & err == '0 & ~timeout_r;
    assign timeout     = timeout_r;
    assign error_count = err;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: nxt = start ? S_WRITE : state;
            S_WRITE:        nxt = acc ? (last ? S_READ_REQ : S_WRITE) : hit ? S_DONE : S_WRITE;
            S_READ_REQ:     nxt = acc ? S_READ_RESP : hit ? S_DONE : S_READ_REQ;
            S_READ_RESP:    nxt = rsp ? S_READ_DRAIN : hit ? S_DONE : S_READ_RESP;
            S_READ_DRAIN:   nxt = bus.bus_resp_valid ? S_READ_DRAIN : last ? S_DONE : S_READ_REQ;
            default:        nxt = S_IDLE;
        endcase
    end
    sdram_tester_watchdog #(.W(TW)) u_wd (
        .clk        (clk),
        .reset      (reset),
        .load       ((nxt != state) | acc),
        .en         (wd_en),
        .load_value (TW'(TIMEOUT - 1)),
        .expired    (wd_exp)
    );
    // error counter only grows, so err==0 doubles as the "no failure latched yet" flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            err         <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            fail_expect <= '0;
            timeout_r   <= 1'b0;
        end else begin
            state <= nxt;
            if ((state == S_IDLE | state == S_DONE) & start) begin
                idx         <= '0;
                err         <= '0;
                fail_addr   <= '0;
                fail_data   <= '0;
                fail_expect <= '0;
                timeout_r   <= 1'b0;
            end
            if (state == S_WRITE & acc) idx <= last ? '0 : idx + 32'd1;
            if (state == S_READ_DRAIN & ~bus.bus_resp_valid & ~last) idx <= idx + 32'd1;
            if (hit) timeout_r <= 1'b1;
            if (rsp & bus.bus_resp_readdata != exp_data) begin
                if (err == '0) begin
                    fail_addr   <= bus.bus_req_address;
                    fail_data   <= bus.bus_resp_readdata;
                    fail_expect <= exp_data;
                end
                if (~&err) err <= err + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_mem_tester.sv
// tb_sdram_mem_tester: three tester instances (16 words, wrapping 4 words, 1 word) each
// behind an ideal memory model; request stream checked against a scoreboard queue.
module tb_sdram_mem_tester;
    import sdram_params_pkg::*;
    localparam int N = 3;
    localparam logic [AVS_DW-1:0] P = 16'h5A5A;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                start_s [N];
    logic                rdy_en  [N];
    int                  burst   [N];
    logic [AVS_DW-1:0]   flip0   [16];
    logic                busy_o [N], done_o [N], pass_o [N], tmo_o [N];
    logic [15:0]         err_o [N];
    logic [AVS_AW-1:0]   fa_o [N];
    logic [AVS_DW-1:0]   fd_o [N], fe_o [N];
    logic                av [N], aw [N], vld [N];
    logic [AVS_AW-1:0]   aa [N];
    logic [AVS_DW-1:0]   ad [N];
    logic [AVS_BYTE-1:0] be [N];

    for (genvar g = 0; g < N; g++) begin : u
        localparam logic [AVS_AW-1:0] ST = (g == 1) ? AVS_AW'((1 << AVS_AW) - 2) : '0;
        localparam int CNT = (g == 0) ? 16 : (g == 1) ? 4 : 1;
        sdram_mem_tester_if bus ();
        sdram_mem_tester #(.ADDR_START(ST), .ADDR_COUNT(CNT), .SEED(32'hA5A5_5A5A), .TIMEOUT(8), .ERR_W(16)) dut (
            .clk(clk), .reset(rst_n), .start(start_s[g]), .busy(busy_o[g]), .done(done_o[g]),
            .pass(pass_o[g]), .timeout(tmo_o[g]), .error_count(err_o[g]), .fail_addr(fa_o[g]),
            .fail_data(fd_o[g]), .fail_expect(fe_o[g]), .bus(bus)
        );
        logic [AVS_DW-1:0] mem [32];
        logic [AVS_DW-1:0] rd;
        logic [AVS_AW-1:0] ra;
        int dly, rem;
        assign bus.bus_req_ready     = rdy_en[g];
        assign bus.bus_resp_valid    = rem > 0;
        assign bus.bus_resp_readdata = rd;
        assign vld[g] = bus.bus_req_valid;
        assign av[g]  = bus.bus_req_valid & bus.bus_req_ready;
        assign aw[g]  = bus.bus_req_write;
        assign aa[g]  = bus.bus_req_address;
        assign ad[g]  = bus.bus_req_writedata;
        assign be[g]  = bus.bus_req_byteenable;
        // read data appears two cycles after acceptance and is held for burst[g] cycles
        always @(posedge clk) begin
            if (!rst_n) begin
                dly <= 0;
                rem <= 0;
            end else begin
                if (av[g] && aw[g]) mem[aa[g][4:0]] <= ad[g];
                if (av[g] && !aw[g]) begin
                    dly <= 2;
                    ra  <= aa[g];
                end else if (dly == 2) dly <= 1;
                else if (dly == 1) begin
                    dly <= 0;
                    rem <= burst[g];
                    rd  <= mem[ra[4:0]] ^ ((g == 0) ? flip0[ra[3:0]] : '0);
                end else if (rem > 0) rem <= rem - 1;
            end
        end
    end

    typedef struct {int k; logic w; logic [AVS_AW-1:0] a; logic [AVS_DW-1:0] d;} txn_t;
    typedef struct {int k; int c1; int c2; int bl; int err; logic [AVS_AW-1:0] fa;
                    logic [AVS_DW-1:0] fd; logic [AVS_DW-1:0] fe; logic ps;} vec_t;
    txn_t exp_q[$];
    vec_t tv[7];
    int checks = 0;
    int fails  = 0;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        txn_t e;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (av[k]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_req inst=%0d got addr=%0h exp none", k, aa[k]);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_txn", 64'({k[1:0], aw[k], aa[k], aw[k] ? ad[k] : 16'h0, be[k]}),
                        64'({e.k[1:0], e.w, e.a, e.d, {AVS_BYTE{1'b1}}}));
                end
            end
        end
    endtask

    function automatic int cnt_of(int k);
        return (k == 0) ? 16 : (k == 1) ? 4 : 1;
    endfunction

    function automatic logic [AVS_AW-1:0] st_of(int k);
        return (k == 1) ? 24'hFFFFFE : 24'h0;
    endfunction

    task automatic launch(int k);
        for (int i = 0; i < cnt_of(k); i++)
            exp_q.push_back('{k, 1'b1, AVS_AW'(st_of(k) + AVS_AW'(i)), P ^ AVS_DW'(i)});
        for (int i = 0; i < cnt_of(k); i++)
            exp_q.push_back('{k, 1'b0, AVS_AW'(st_of(k) + AVS_AW'(i)), 16'h0});
        start_s[k] = 1'b1;
        tick();
        start_s[k] = 1'b0;
    endtask

    task automatic wait_done(int k);
        int c = 0;
        while (!done_o[k] && c < 3000) begin
            tick();
            c++;
        end
        chk("done_in_time", 64'(done_o[k]), 64'(1));
    endtask

    initial begin
        int c;
        for (int k = 0; k < N; k++) begin
            start_s[k] = 1'b0;
            rdy_en[k]  = 1'b1;
            burst[k]   = 1;
        end
        foreach (flip0[i]) flip0[i] = '0;
        tv[0] = '{0, -1, -1, 1, 0, 24'd0, 16'h0, 16'h0, 1'b1};
        tv[1] = '{0,  5, -1, 1, 1, 24'd5, P ^ 16'd5 ^ 16'd1, P ^ 16'd5, 1'b0};
        tv[2] = '{0,  3,  9, 1, 2, 24'd3, P ^ 16'd3 ^ 16'd1, P ^ 16'd3, 1'b0};
        tv[3] = '{0, -1, -1, 4, 0, 24'd0, 16'h0, 16'h0, 1'b1};
        tv[4] = '{0,  7, -1, 4, 1, 24'd7, P ^ 16'd7 ^ 16'd1, P ^ 16'd7, 1'b0};
        tv[5] = '{1, -1, -1, 1, 0, 24'd0, 16'h0, 16'h0, 1'b1};
        tv[6] = '{2, -1, -1, 2, 0, 24'd0, 16'h0, 16'h0, 1'b1};
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < N; k++) begin
            chk("rst_busy", 64'(busy_o[k]), 64'(0));
            chk("rst_done", 64'(done_o[k]), 64'(0));
            chk("rst_pass", 64'(pass_o[k]), 64'(0));
            chk("rst_timeout", 64'(tmo_o[k]), 64'(0));
            chk("rst_err", 64'(err_o[k]), 64'(0));
            chk("rst_fail", 64'({fa_o[k], fd_o[k], fe_o[k]}), 64'(0));
            chk("rst_valid", 64'(vld[k]), 64'(0));
        end
        for (int v = 0; v < 7; v++) begin
            foreach (flip0[i]) flip0[i] = '0;
            if (tv[v].c1 >= 0) flip0[tv[v].c1] = 16'h1;
            if (tv[v].c2 >= 0) flip0[tv[v].c2] = 16'h1;
            burst[tv[v].k] = tv[v].bl;
            launch(tv[v].k);
            wait_done(tv[v].k);
            chk($sformatf("v%0d_pass", v), 64'(pass_o[tv[v].k]), 64'(tv[v].ps));
            chk($sformatf("v%0d_err", v), 64'(err_o[tv[v].k]), 64'(tv[v].err));
            chk($sformatf("v%0d_fail_addr", v), 64'(fa_o[tv[v].k]), 64'(tv[v].fa));
            chk($sformatf("v%0d_fail_data", v), 64'(fd_o[tv[v].k]), 64'(tv[v].fd));
            chk($sformatf("v%0d_fail_expect", v), 64'(fe_o[tv[v].k]), 64'(tv[v].fe));
            chk($sformatf("v%0d_timeout", v), 64'(tmo_o[tv[v].k]), 64'(0));
            chk($sformatf("v%0d_busy", v), 64'(busy_o[tv[v].k]), 64'(0));
            chk($sformatf("v%0d_queue", v), 64'(exp_q.size()), 64'(0));
        end
        foreach (flip0[i]) flip0[i] = '0;
        burst[0] = 1;
        // a second start mid-run must not restart the sequence
        launch(0);
        repeat (5) tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        wait_done(0);
        chk("busy_start_pass", 64'(pass_o[0]), 64'(1));
        chk("busy_start_queue", 64'(exp_q.size()), 64'(0));
        rdy_en[0] = 1'b0;
        launch(0);
        chk("to_valid_in_write", 64'(vld[0]), 64'(1));
        c = 1;
        while (!done_o[0] && c < 50) begin
            tick();
            c++;
        end
        chk("to_cycles", 64'(c), 64'(9));
        chk("to_timeout", 64'(tmo_o[0]), 64'(1));
        chk("to_pass", 64'(pass_o[0]), 64'(0));
        chk("to_valid", 64'(vld[0]), 64'(0));
        exp_q.delete();
        rdy_en[0] = 1'b1;
        flip0[0] = 16'h1;
        launch(0);
        c = 0;
        while (!(vld[0] && !aw[0] && aa[0] == 24'd2) && c < 500) begin
            tick();
            c++;
        end
        chk("mid_read_reached", 64'(vld[0] && !aw[0]), 64'(1));
        chk("mid_read_err", 64'(err_o[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid_drop", 64'(vld[0]), 64'(0));
        tick();
        chk("mid_reset_busy", 64'(busy_o[0]), 64'(0));
        chk("mid_reset_done", 64'(done_o[0]), 64'(0));
        chk("mid_reset_pass_to", 64'({pass_o[0], tmo_o[0]}), 64'(0));
        chk("mid_reset_err", 64'(err_o[0]), 64'(0));
        chk("mid_reset_fail", 64'({fa_o[0], fd_o[0], fe_o[0]}), 64'(0));
        chk("mid_reset_valid", 64'(vld[0]), 64'(0));
        exp_q.delete();
        flip0[0] = '0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset", 64'({busy_o[0], done_o[0], vld[0]}), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
